// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op encodings, FSM state type and the reference bitwise op function
package logic_unit_pkg;
  localparam int MAX_W = 64;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_IMP  = 3'd6;
  localparam logic [2:0] OP_NIMP = 3'd7;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;
  // Operates at MAX_W bits; callers zero-extend operands and truncate the result.
  function automatic logic [MAX_W-1:0] apply_op(input logic [2:0] op, input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
    case (op)
      OP_OR:   apply_op = a | b;
      OP_XOR:  apply_op = a ^ b;
      OP_NAND: apply_op = ~(a & b);
      OP_NOR:  apply_op = ~(a | b);
      OP_XNOR: apply_op = ~(a ^ b);
      OP_IMP:  apply_op = ~a | b;
      OP_NIMP: apply_op = a & ~b;
      default: apply_op = a & b;
    endcase
  endfunction
endpackage

// File: rtl/logic_op_bitwise.sv
// logic_op_bitwise: combinational WIDTH-bit op select in front of the result register
module logic_op_bitwise
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = WIDTH'(apply_op(i_op, MAX_W'(i_a), MAX_W'(i_b)));
endmodule

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: registered bitwise logic unit with valid/ready stream and packet accumulate mode
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_r;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accum;
  logic             w_accept;
  logic             w_full;
  logic             w_emit;

  assign in_ready   = !out_valid || out_ready;
  assign w_accum    = r_state == ST_ACCUM;
  assign w_accept   = in_valid && in_ready;
  assign w_opa      = w_accum ? r_acc : in_a;
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_full     = w_cnt_next == CNT_W'(MAX_BEATS);
  // Mid-packet beats fold into the accumulator; everything else produces a result.
  assign w_emit     = w_accum ? (in_last || w_full) : (!in_acc || in_last);

  logic_op_bitwise #(.WIDTH(WIDTH)) u_op (
    .i_op (in_op),
    .i_a  (w_opa),
    .i_b  (in_b),
    .o_y  (w_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (w_accept && w_emit) begin
        out_valid <= 1'b1;
        out_y     <= w_r;
        out_count <= w_accum ? w_cnt_next : CNT_W'(1);
        out_ovf   <= w_accum && !in_last;
        r_state   <= ST_IDLE;
        r_acc     <= '0;
        r_cnt     <= '0;
      end else if (w_accept) begin
        r_state   <= ST_ACCUM;
        r_acc     <= w_r;
        r_cnt     <= w_cnt_next;
      end
    end
  end
endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: directed self-checking bench for logic_unit_seq (WIDTH=4, MAX_BEATS=4)
module tb_logic_unit_seq;
  localparam int W  = 4;
  localparam int MB = 4;
  localparam int CW = 3;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    in_op = '0;
  logic          in_acc = 1'b0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_y;
  logic [CW-1:0] out_count;
  logic          out_ovf;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] sweep_exp [8];

  logic_unit_seq #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic acc, input logic last);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_acc = acc;
    in_last = last;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] y, input logic [CW-1:0] cnt, input logic ovf);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_y"}, 32'(out_y), 32'(y));
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
  endtask

  initial begin
    sweep_exp = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1011, 4'b0100};
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(out_y), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    // single IMP beat
    beat(3'd6, 4'b1100, 4'b1010, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk_out("imp1", 4'b1011, 3'd1, 1'b0);
    cyc();
    chk("imp1_drain", 32'(out_valid), 32'd0);
    // back-to-back sweep of all ops; 1100/1010 covers every bit pair
    for (int i = 0; i < 8; i++) begin
      beat(3'(i), 4'b1100, 4'b1010, 1'b0, 1'b0);
      cyc();
      chk($sformatf("sweep_op%0d", i), 32'(out_y), 32'(sweep_exp[i]));
      chk($sformatf("sweep_v%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    cyc();
    // AND accumulate over 3 beats; in_a and in_acc ignored mid-packet
    beat(3'd0, 4'b1111, 4'b1110, 1'b1, 1'b0);
    cyc();
    chk("acc_b1_valid", 32'(out_valid), 32'd0);
    beat(3'd0, 4'b0000, 4'b0111, 1'b0, 1'b0);
    cyc();
    chk("acc_b2_valid", 32'(out_valid), 32'd0);
    beat(3'd0, 4'b0000, 4'b1101, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk_out("acc", 4'b0100, 3'd3, 1'b0);
    cyc();
    // backpressure with a waiting beat
    out_ready = 1'b0;
    beat(3'd2, 4'b1100, 4'b1010, 1'b0, 1'b0);
    cyc();
    beat(3'd1, 4'b0001, 4'b0010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_ready%0d", i), 32'(in_ready), 32'd0);
      chk_out($sformatf("bp_hold%0d", i), 4'b0110, 3'd1, 1'b0);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk_out("bp_next", 4'b0011, 3'd1, 1'b0);
    cyc();
    chk("bp_drain", 32'(out_valid), 32'd0);
    chk("bp_ready_end", 32'(in_ready), 32'd1);
    // XOR packet overflowing at MAX_BEATS=4
    beat(3'd2, 4'b0001, 4'b0010, 1'b1, 1'b0);
    cyc();
    chk("ovf_b1", 32'(out_valid), 32'd0);
    beat(3'd2, 4'b0000, 4'b0100, 1'b1, 1'b0);
    cyc();
    chk("ovf_b2", 32'(out_valid), 32'd0);
    beat(3'd2, 4'b0000, 4'b1000, 1'b1, 1'b0);
    cyc();
    chk("ovf_b3", 32'(out_valid), 32'd0);
    beat(3'd2, 4'b0000, 4'b0001, 1'b1, 1'b0);
    cyc();
    chk_out("ovf_out", 4'b1110, 3'd4, 1'b1);
    beat(3'd2, 4'b0101, 4'b0011, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk_out("ovf_b5", 4'b0110, 3'd1, 1'b0);
    cyc();
    // reset mid-packet
    beat(3'd0, 4'b1111, 4'b1010, 1'b1, 1'b0);
    cyc();
    beat(3'd0, 4'b0000, 4'b1000, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_count", 32'(out_count), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    beat(3'd0, 4'b1010, 4'b0110, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    chk_out("mrst_and", 4'b0010, 3'd1, 1'b0);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
